// File: rtl/acia_fifo.sv
// acia_fifo: buffered 6850-style ACIA front end with RX/TX FIFOs.
//
// Two-register CPU interface: mode_in=0 selects control (write) or status
// (read); mode_in=1 selects the data FIFOs. Received bytes from the uart are
// queued in the RX FIFO; CPU data writes are queued in the TX FIFO and are
// drained into the uart by a small handshake state machine.
//
// Ports:
//   clk_in, rst_n_in             clock, async active-low reset
//   mode_in, read_in, write_in   CPU register select and strobes
//   bus_io                       CPU data bus, driven only while read_in=1
//   uart_rx_data_in/ready_in     received byte and its ready flag
//   uart_tx_ready_in             uart transmitter idle
//   uart_tx_data_out/start_out   byte to send and one-cycle send pulse
//   tx_break_out                 break request from control TC=11
//   irq_out                      registered interrupt request
module acia_fifo #(
    parameter int DEPTH_LOG2   = 4,
    parameter int RX_THRESH    = 1,
    parameter int TX_LOW_WATER = 0,
    parameter bit SEVEN_BIT    = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       mode_in,
    input  logic       read_in,
    input  logic       write_in,
    inout  wire  [7:0] bus_io,
    input  logic [7:0] uart_rx_data_in,
    input  logic       uart_rx_ready_in,
    input  logic       uart_tx_ready_in,
    output logic [7:0] uart_tx_data_out,
    output logic       uart_start_out,
    output logic       tx_break_out,
    output logic       irq_out
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         FULL    = CW'(1 << DEPTH_LOG2);
    localparam logic [CW-1:0]         CNT_ONE = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [CW-1:0]         RX_TH   = CW'(RX_THRESH);
    localparam logic [CW-1:0]         TX_LW   = CW'(TX_LOW_WATER);

    typedef enum logic [1:0] {TX_IDLE, TX_BUSY, TX_DONE} tx_state_t;

    // Control fields; word-select bits 4:2 have no function in this block.
    logic       rie_q;
    logic [1:0] tc_q;
    logic [1:0] cr_q;
    logic       mrst;

    logic ctrl_wr, data_wr, data_rd;
    assign ctrl_wr = write_in & ~mode_in;
    assign data_wr = write_in & mode_in;
    assign data_rd = read_in & mode_in;
    assign mrst    = (cr_q == 2'b11);

    // ---------------- RX side ----------------
    logic [7:0]            rx_mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] rx_wr_q, rx_rd_q;
    logic [CW-1:0]         rx_cnt_q;
    logic                  rx_rdy_q, rx_rdy_qq;
    logic [7:0]            rx_byte_q, hold_q;
    logic                  ovrn_q;
    logic                  rx_empty, rx_full, rx_edge, rx_pop, rx_push, rx_ovf;

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL);
    // Edge seen on the registered copy, so the push lands one cycle later.
    assign rx_edge  = rx_rdy_q & ~rx_rdy_qq;
    assign rx_pop   = data_rd & ~rx_empty;
    // A pop in the same cycle frees a slot, so full+push+pop is not overrun.
    assign rx_push  = rx_edge & ~mrst & (~rx_full | rx_pop);
    assign rx_ovf   = rx_edge & ~mrst & rx_full & ~rx_pop;

    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_wr_q] <= rx_byte_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_rdy_q  <= 1'b0;
            rx_rdy_qq <= 1'b0;
            rx_byte_q <= '0;
            hold_q    <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            rx_cnt_q  <= '0;
            ovrn_q    <= 1'b0;
        end else begin
            rx_rdy_q  <= uart_rx_ready_in;
            rx_rdy_qq <= rx_rdy_q;
            rx_byte_q <= uart_rx_data_in;
            if (rx_pop) hold_q <= rx_mem[rx_rd_q];
            if (mrst) begin
                rx_wr_q  <= '0;
                rx_rd_q  <= '0;
                rx_cnt_q <= '0;
                ovrn_q   <= 1'b0;
            end else begin
                if (rx_push) rx_wr_q <= rx_wr_q + PTR_ONE;
                if (rx_pop)  rx_rd_q <= rx_rd_q + PTR_ONE;
                if (rx_push & ~rx_pop)      rx_cnt_q <= rx_cnt_q + CNT_ONE;
                else if (rx_pop & ~rx_push) rx_cnt_q <= rx_cnt_q - CNT_ONE;
                if (rx_ovf)       ovrn_q <= 1'b1;
                else if (data_rd) ovrn_q <= 1'b0;
            end
        end
    end

    // ---------------- TX side ----------------
    logic [7:0]            tx_mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] tx_wr_q, tx_rd_q;
    logic [CW-1:0]         tx_cnt_q;
    logic [7:0]            tx_byte, tx_data_q;
    logic                  tx_empty, tx_full, tx_push, tx_pop, start_q;
    tx_state_t             state_q, state_d;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FULL);
    assign tx_push  = data_wr & ~mrst & ~tx_full;
    assign tx_byte  = SEVEN_BIT ? {1'b0, bus_io[6:0]} : bus_io;

    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem[tx_wr_q] <= tx_byte;
    end

    // BUSY/DONE ignore master reset so a byte in flight finishes cleanly.
    always_comb begin
        state_d = state_q;
        tx_pop  = 1'b0;
        case (state_q)
            TX_IDLE: if (~tx_empty & uart_tx_ready_in & ~mrst) begin
                tx_pop  = 1'b1;
                state_d = TX_BUSY;
            end
            TX_BUSY: if (~uart_tx_ready_in) state_d = TX_DONE;
            TX_DONE: if (uart_tx_ready_in)  state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= TX_IDLE;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            tx_cnt_q  <= '0;
            tx_data_q <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= tx_pop;
            if (tx_pop) tx_data_q <= tx_mem[tx_rd_q];
            if (mrst) begin
                tx_wr_q  <= '0;
                tx_rd_q  <= '0;
                tx_cnt_q <= '0;
            end else begin
                if (tx_push) tx_wr_q <= tx_wr_q + PTR_ONE;
                if (tx_pop)  tx_rd_q <= tx_rd_q + PTR_ONE;
                if (tx_push & ~tx_pop)      tx_cnt_q <= tx_cnt_q + CNT_ONE;
                else if (tx_pop & ~tx_push) tx_cnt_q <= tx_cnt_q - CNT_ONE;
            end
        end
    end

    // ---------------- control / irq ----------------
    logic irq_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rie_q <= 1'b0;
            tc_q  <= 2'b00;
            cr_q  <= 2'b00;
            irq_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                rie_q <= bus_io[7];
                tc_q  <= bus_io[6:5];
                cr_q  <= bus_io[1:0];
            end
            irq_q <= ~mrst & ((rie_q & ((rx_cnt_q >= RX_TH) | ovrn_q)) |
                              ((tc_q == 2'b01) & (tx_cnt_q <= TX_LW)));
        end
    end

    // ---------------- bus read path ----------------
    logic [7:0] status, rd_byte;
    assign status  = {irq_q, 1'b0, ovrn_q, 3'b000, ~tx_full, ~rx_empty};
    assign rd_byte = ~mode_in ? status : (rx_empty ? hold_q : rx_mem[rx_rd_q]);
    assign bus_io  = read_in ? rd_byte : 8'hzz;

    assign uart_tx_data_out = tx_data_q;
    assign uart_start_out   = start_q;
    assign tx_break_out     = (tc_q == 2'b11);
    assign irq_out          = irq_q;
endmodule
